// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a one-entry valid/ready holding register.
// Define UART_RX_PARITY_EN for 8E1 framing with an rx_parity_err pulse.
module uart_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_frame_err,
  output logic       rx_overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic       rx_parity_err
`endif
);
  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam logic [15:0] BIT_END = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_END = 16'(BAUD_DIV / 2 - 1);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA = 3'd2;
  localparam logic [2:0] STOP = 3'd3;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd4;
  logic par_q, par_d, perr_q, perr_d;
`endif
  logic [1:0] sync_q, fill_q;
  logic prev_q, armed_q, armed_d, rx_s;
  logic [2:0] state_q, state_d, bit_q, bit_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d, data_q, data_d;
  logic valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d;

  assign rx_s = sync_q[1];
  // fill_q keeps the reset-value ones in the synchronizer from arming the receiver
  assign armed_d = armed_q | (fill_q[1] & rx_s);

  always_comb begin
    state_d = state_q;
    cnt_d = (state_q == IDLE) ? '0 : cnt_q + 16'd1;
    bit_d = bit_q;
    shift_d = shift_q;
    data_d = data_q;
    valid_d = valid_q & ~rx_ready;
    ferr_d = 1'b0;
    ovr_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d = par_q;
    perr_d = 1'b0;
`endif
    case (state_q)
      IDLE: if (armed_q && prev_q && !rx_s) state_d = START;
      START: if (cnt_q == HALF_END) begin
        state_d = rx_s ? IDLE : DATA;
        cnt_d = '0;
        bit_d = '0;
      end
      DATA: if (cnt_q == BIT_END) begin
        shift_d[bit_q] = rx_s;
        bit_d = bit_q + 3'd1;
        cnt_d = '0;
`ifdef UART_RX_PARITY_EN
        if (bit_q == 3'd7) state_d = PARITY;
`else
        if (bit_q == 3'd7) state_d = STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (cnt_q == BIT_END) begin
        par_d = rx_s;
        state_d = STOP;
        cnt_d = '0;
      end
`endif
      STOP: if (cnt_q == BIT_END) begin
        state_d = IDLE;
        cnt_d = '0;
        ferr_d = ~rx_s;
        ovr_d = rx_s & valid_q & ~rx_ready;
        if (rx_s && (!valid_q || rx_ready)) begin
          data_d = shift_q;
          valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          perr_d = ^{shift_q, par_q};
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
      fill_q <= 2'b00;
      prev_q <= 1'b1;
      armed_q <= 1'b0;
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q <= 1'b0;
      perr_q <= 1'b0;
`endif
    end else begin
      sync_q <= {sync_q[0], serial_rx};
      fill_q <= {fill_q[0], 1'b1};
      prev_q <= rx_s;
      armed_q <= armed_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      data_q <= data_d;
      valid_q <= valid_d;
      ferr_q <= ferr_d;
      ovr_q <= ovr_d;
`ifdef UART_RX_PARITY_EN
      par_q <= par_d;
      perr_q <= perr_d;
`endif
    end
  end

  assign rx_data = data_q;
  assign rx_valid = valid_q;
  assign rx_frame_err = ferr_q;
  assign rx_overrun = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign rx_parity_err = perr_q;
`endif
endmodule
